// File: rtl/ec_pkg.sv
// Shared types and helpers for the erasure-coding bitmatrix MAC datapath.
package ec_pkg;

  localparam int EC_W             = 4;
  localparam int EC_PACKET_LENGTH = 2;
  localparam int EC_K_MIN         = 2;
  localparam int EC_K_MAX         = 128;
  localparam int EC_KW            = $clog2(EC_K_MAX + 1);

  // One data packet word, a W-word chunk/parity, and a W x W bitmatrix tile
  typedef logic [EC_PACKET_LENGTH-1:0] word_t;
  typedef word_t [EC_W-1:0]            chunk_t;
  typedef logic [EC_W-1:0][EC_W-1:0]   tile_t;
  typedef logic [EC_KW-1:0]            kcnt_t;

  // Input-side frame state: no frame open, accumulating, final chunk taken
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  // Clamp a requested chunk count into the legal range
  function automatic kcnt_t clamp_k(input kcnt_t k, input kcnt_t kmin, input kcnt_t kmax);
    if (k < kmin) return kmin;
    if (k > kmax) return kmax;
    return k;
  endfunction

  // True when a requested chunk count had to be clamped
  function automatic logic k_out_of_range(input kcnt_t k, input kcnt_t kmin, input kcnt_t kmax);
    return (k < kmin) || (k > kmax);
  endfunction

endpackage

// File: rtl/bm_tile_mult.sv
// GF(2) tile product: output word j is the XOR of every data packet i whose
// select bit bitmatrix_cols[j][i] is set. Purely combinational.
module bm_tile_mult
  import ec_pkg::*;
(
  input  tile_t  bitmatrix_cols_i,
  input  chunk_t data_packet_i,
  output chunk_t prod_o
);

  generate
    for (genvar gi = 0; gi < EC_W; gi++) begin : g_col
      word_t col_x;

      // AND-mask each packet with its select bit, then XOR-reduce the column
      always_comb begin
        col_x = '0;
        for (int i = 0; i < EC_W; i++) begin
          col_x = col_x ^ (data_packet_i[i] & {EC_PACKET_LENGTH{bitmatrix_cols_i[gi][i]}});
        end
      end

      assign prod_o[gi] = col_x;
    end
  endgenerate

endmodule

// File: rtl/bm_mac_unit.sv
// Bitmatrix multiply-accumulate engine: XOR-accumulates k tile products and
// presents one parity chunk per frame. Optional macro BM_MAC_PIPE_EN inserts a
// register stage between the tile multiply and the accumulator.
module bm_mac_unit
  import ec_pkg::*;
#(
  parameter int W             = EC_W,
  parameter int PACKET_LENGTH = EC_PACKET_LENGTH,
  parameter int K_MIN         = EC_K_MIN,
  parameter int K_MAX         = EC_K_MAX,
  localparam int KW           = $clog2(K_MAX + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [KW-1:0]                     k_cfg,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [W-1:0][W-1:0]               bitmatrix_cols,
  input  logic [W-1:0][PACKET_LENGTH-1:0]   data_packet,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [W-1:0][PACKET_LENGTH-1:0]   parity_packet,
  output logic                              cfg_err,
  output logic                              busy
);

  mac_state_e state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_lat_q, k_lat_d;
  logic [W-1:0][PACKET_LENGTH-1:0] acc_q, acc_d;
  logic [W-1:0][PACKET_LENGTH-1:0] result_q, result_d;
  logic out_valid_q, out_valid_d;
  logic cfg_err_q, cfg_err_d;

  chunk_t prod;
  logic   in_ready_int;
  logic   accept, first_chunk, final_accept;
  logic [KW-1:0] k_eff;
  logic   feed_valid, feed_last;
  logic [W-1:0][PACKET_LENGTH-1:0] feed_prod;
  logic   stage_busy;

  bm_tile_mult u_tile_mult (
    .bitmatrix_cols_i (bitmatrix_cols),
    .data_packet_i    (data_packet),
    .prod_o           (prod)
  );

  // A frame is open only in ACC; IDLE and DONE both mean the next accept is a first chunk
  assign first_chunk  = (state_q != ACC);
  assign k_eff        = first_chunk ? clamp_k(k_cfg, kcnt_t'(K_MIN), kcnt_t'(K_MAX)) : k_lat_q;
  assign accept       = in_valid && in_ready_int;
  assign final_accept = accept && (cnt_q == k_eff - KW'(1));

`ifdef BM_MAC_PIPE_EN
  logic stg_valid_q, stg_last_q;
  logic [W-1:0][PACKET_LENGTH-1:0] stg_prod_q;
  logic advance;

  // Stage stalls only when it holds a last product that cannot yet overwrite a pending result
  assign advance      = !(stg_valid_q && stg_last_q && out_valid_q && !out_ready);
  assign in_ready_int = advance;
  assign feed_valid   = stg_valid_q && advance;
  assign feed_last    = stg_last_q;
  assign feed_prod    = stg_prod_q;
  assign stage_busy   = stg_valid_q;

  // Product/last-flag register between the multiplier and the accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_last_q  <= 1'b0;
      stg_prod_q  <= '0;
    end else if (advance) begin
      stg_valid_q <= accept;
      stg_last_q  <= final_accept;
      stg_prod_q  <= prod;
    end
  end
`else
  assign in_ready_int = !out_valid_q || out_ready;
  assign feed_valid   = accept;
  assign feed_last    = final_accept;
  assign feed_prod    = prod;
  assign stage_busy   = 1'b0;
`endif

  // State register plus counter, accumulator and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_lat_q     <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_lat_q     <= k_lat_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Next state and next datapath values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_lat_d     = k_lat_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q && !out_ready;
    cfg_err_d   = 1'b0;

    if (accept) begin
      state_d = final_accept ? DONE : ACC;
      cnt_d   = final_accept ? '0 : cnt_q + KW'(1);
      if (first_chunk) begin
        k_lat_d   = k_eff;
        cfg_err_d = k_out_of_range(k_cfg, kcnt_t'(K_MIN), kcnt_t'(K_MAX));
      end
    end else if (state_q == DONE && out_valid_q && out_ready && !(feed_valid && feed_last)) begin
      state_d = IDLE;
    end

    // The accumulator is zero at every frame start, so XOR covers the first chunk too
    if (feed_valid) begin
      if (feed_last) begin
        result_d    = acc_q ^ feed_prod;
        acc_d       = '0;
        out_valid_d = 1'b1;
      end else begin
        acc_d = acc_q ^ feed_prod;
      end
    end
  end

  // Output drive from registered state
  always_comb begin
    in_ready      = in_ready_int;
    out_valid     = out_valid_q;
    parity_packet = result_q;
    cfg_err       = cfg_err_q;
    busy          = (cnt_q != '0) || out_valid_q || stage_busy;
  end

endmodule

// File: tb/tb_bm_mac_unit.sv
// Self-checking bench for bm_mac_unit (default build, no register stage).
module tb_bm_mac_unit;
  import ec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] k_cfg = 8'd2;
  logic       in_valid = 1'b0;
  logic       in_ready;
  tile_t      bitmatrix_cols = '0;
  chunk_t     data_packet = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  chunk_t     parity_packet;
  logic       cfg_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic rand_ready = 1'b0;

  // Reference model state
  logic   m_ov  = 1'b0;
  logic   m_cfg = 1'b0;
  int     m_cnt = 0;
  int     m_k   = 0;
  chunk_t m_acc = '0;
  chunk_t m_par = '0;

  bm_mac_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .k_cfg          (k_cfg),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .bitmatrix_cols (bitmatrix_cols),
    .data_packet    (data_packet),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .parity_packet  (parity_packet),
    .cfg_err        (cfg_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic chunk_t tile_prod(input tile_t t, input chunk_t d);
    chunk_t r;
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        if (t[j][i]) r[j] = r[j] ^ d[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: count accepted chunks, XOR their products, publish after k
  always @(posedge clk) begin : model
    chunk_t acc_n, par_n;
    int cnt_n, k_n;
    logic ov_n, cfg_n;
    if (!rst_n) begin
      m_ov  <= 1'b0;
      m_cfg <= 1'b0;
      m_cnt <= 0;
      m_k   <= 0;
      m_acc <= '0;
      m_par <= '0;
    end else begin
      acc_n = m_acc;
      par_n = m_par;
      cnt_n = m_cnt;
      k_n   = m_k;
      cfg_n = 1'b0;
      ov_n  = m_ov && !out_ready;
      if (in_valid && (!m_ov || out_ready)) begin
        if (cnt_n == 0) begin
          k_n = int'(k_cfg);
          if (k_n < 2) begin k_n = 2; cfg_n = 1'b1; end
          else if (k_n > 128) begin k_n = 128; cfg_n = 1'b1; end
        end
        acc_n = acc_n ^ tile_prod(bitmatrix_cols, data_packet);
        cnt_n = cnt_n + 1;
        if (cnt_n == k_n) begin
          par_n = acc_n;
          acc_n = '0;
          cnt_n = 0;
          ov_n  = 1'b1;
        end
      end
      m_ov  <= ov_n;
      m_cfg <= cfg_n;
      m_cnt <= cnt_n;
      m_k   <= k_n;
      m_acc <= acc_n;
      m_par <= par_n;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, m_ov);
      chk("in_ready", in_ready, !m_ov || out_ready);
      chk("parity", parity_packet, m_par);
      chk("busy", busy, (m_cnt != 0) || m_ov);
      chk("cfg_err", cfg_err, m_cfg);
    end
  end

  // Random output backpressure when enabled
  always @(negedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Present one chunk and hold it until the edge that accepts it
  task automatic send(input tile_t t, input chunk_t d, input logic [7:0] kc);
    int n;
    logic ok;
    n = 0;
    bitmatrix_cols = t;
    data_packet    = d;
    k_cfg          = kc;
    in_valid       = 1'b1;
    forever begin
      ok = !m_ov || out_ready;
      step();
      if (ok) break;
      n++;
      if (n > 50) begin
        errors++;
        $display("FAIL accept_timeout: chunk not accepted within 50 cycles (t=%0t)", $time);
        break;
      end
    end
    in_valid = 1'b0;
    $display("chunk tile=%h data=%h k_cfg=%0d out_valid=%0b parity=%h", t, d, kc, out_valid, parity_packet);
  endtask

  localparam tile_t ID_TILE = 16'h8421;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int kr;
    // Reset state
    repeat (2) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_parity", parity_packet, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    // Identity tile, k=2: {1,2,3,0} ^ {3,3,3,3} = {2,1,0,3}
    send(ID_TILE, 8'h39, 8'd2);
    send(ID_TILE, 8'hFF, 8'd2);
    chk("id_out_valid", out_valid, 1'b1);
    chk("id_parity", parity_packet, 8'hC6);
    step();

    // All-zero tile, k=4
    for (int c = 0; c < 4; c++) send('0, chunk_t'($urandom), 8'd4);
    chk("zero_out_valid", out_valid, 1'b1);
    chk("zero_parity", parity_packet, 8'h00);
    step();
    chk("zero_busy", busy, 1'b0);

    // Backpressure: result held while out_ready=0, next chunk waits
    out_ready = 1'b0;
    send(ID_TILE, 8'h12, 8'd2);
    send(ID_TILE, 8'h34, 8'd2);
    bitmatrix_cols = ID_TILE;
    data_packet    = 8'h0F;
    k_cfg          = 8'd2;
    in_valid       = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_parity", parity_packet, 8'h26);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    send(ID_TILE, 8'hF0, 8'd2);
    chk("bp_next_parity", parity_packet, 8'hFF);
    step();

    // k_cfg below range clamps to 2
    send(ID_TILE, 8'hA5, 8'd1);
    chk("klow_cfg_err", cfg_err, 1'b1);
    send(ID_TILE, 8'h5A, 8'd7);
    chk("klow_out_valid", out_valid, 1'b1);
    chk("klow_parity", parity_packet, 8'hFF);
    step();

    // k_cfg above range clamps to 128; later k_cfg values are ignored
    send(tile_t'($urandom), chunk_t'($urandom), 8'd200);
    chk("khigh_cfg_err", cfg_err, 1'b1);
    for (int c = 1; c < 127; c++) send(tile_t'($urandom), chunk_t'($urandom), 8'd3);
    chk("khigh_127_out_valid", out_valid, 1'b0);
    send(tile_t'($urandom), chunk_t'($urandom), 8'd3);
    chk("khigh_128_out_valid", out_valid, 1'b1);
    step();

    // Back-to-back k=3 frames with in_valid and out_ready held high
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 3; c++) begin
        bitmatrix_cols = tile_t'($urandom);
        data_packet    = chunk_t'($urandom);
        k_cfg          = 8'd3;
        in_valid       = 1'b1;
        step();
        $display("b2b frame=%0d chunk=%0d out_valid=%0b parity=%h", f, c, out_valid, parity_packet);
      end
      chk("b2b_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    step();

    // Reset after one chunk of a k=3 frame discards the partial sum
    send(ID_TILE, 8'hC3, 8'd3);
    rst_n = 1'b0;
    step();
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_parity", parity_packet, 8'h00);
    chk("mrst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    step();
    send(ID_TILE, 8'h5A, 8'd2);
    send(ID_TILE, 8'h0F, 8'd2);
    chk("mrst_next_parity", parity_packet, 8'h55);
    step();

    // Randomized frames with random backpressure and gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kr = $urandom_range(2, 6);
      if ($urandom_range(0, 7) == 0) kr = ($urandom_range(0, 1) == 0) ? 0 : 250;
      for (int c = 0; c < ((kr < 2) ? 2 : (kr > 128) ? 128 : kr); c++) begin
        send(tile_t'($urandom), chunk_t'($urandom), 8'(kr));
        if ($urandom_range(0, 3) == 0) step();
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    repeat (4) step();
    chk("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
